// File: rtl/inst_encoder_loader.sv
// Streaming RV32I instruction encoder and program loader: packs decoded fields
// into 32-bit words, range-checks immediates, and writes them to instruction memory.
module inst_encoder_loader #(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    ADDR_W   = 8,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic              err_full,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   next_addr;
  logic [XLEN-1:0]     enc_c;
  logic                imm_ok_c;
  logic                accept_c;
  logic                start_ok_c;
  logic                at_top_c;

  assign accept_c   = in_valid && (state == LOAD);
  assign start_ok_c = start && ((state == IDLE) || (state == DONE));
  assign at_top_c   = (next_addr == {ADDR_W{1'b1}});

  // Field packing and immediate range check per instruction format
  always_comb begin
    enc_c    = '0;
    imm_ok_c = 1'b1;
    unique case (in_type)
      2'b00: begin
        enc_c    = XLEN'({in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode});
        imm_ok_c = (in_imm[XLEN-1:11] == {(XLEN-11){in_imm[11]}});
      end
      2'b01: begin
        enc_c    = XLEN'({in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode});
        imm_ok_c = (in_imm[XLEN-1:11] == {(XLEN-11){in_imm[11]}});
      end
      2'b10: begin
        enc_c    = XLEN'({in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode});
        imm_ok_c = (in_imm[XLEN-1:12] == {(XLEN-12){in_imm[12]}}) && !in_imm[0];
      end
      2'b11: begin
        enc_c    = XLEN'({in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode});
        imm_ok_c = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = LOAD;
      LOAD:  if (accept_c && (in_last || at_top_c)) state_next = DRAIN;
      DRAIN: state_next = DONE;
      DONE:  if (start) state_next = LOAD;
    endcase
  end

  // Status flags track the state the FSM is entering
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_next == LOAD);
      busy     <= (state_next == LOAD) || (state_next == DRAIN);
      done     <= (state_next == DONE);
    end
  end

  // Write port, address/count tracking and sticky error capture
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      next_addr  <= '0;
      word_count <= '0;
      err_range  <= 1'b0;
      err_full   <= 1'b0;
      err_addr   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok_c) begin
        next_addr  <= '0;
        word_count <= '0;
        err_range  <= 1'b0;
        err_full   <= 1'b0;
        err_addr   <= '0;
      end
      if (accept_c) begin
        mem_we     <= 1'b1;
        mem_addr   <= next_addr;
        mem_wdata  <= imm_ok_c ? enc_c : NOP_WORD;
        next_addr  <= next_addr + ADDR_W'(1);
        word_count <= word_count + CNT_W'(1);
        if (!imm_ok_c) begin
          err_range <= 1'b1;
          if (!err_range) err_addr <= next_addr;
        end
        if (at_top_c && !in_last) err_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed self-checking bench for inst_encoder_loader with hand-computed encodings.
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic        in_ready, mem_we, busy, done, err_range, err_full;
  logic [1:0]  in_type;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm, mem_wdata;
  logic [7:0]  mem_addr, err_addr;
  logic [8:0]  word_count;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  inst_encoder_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err_range(err_range), .err_full(err_full),
    .err_addr(err_addr), .word_count(word_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [1:0] t, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm, input logic last);
    in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one word for a single cycle; the DUT is in LOAD so it is accepted
  task automatic send(input logic [1:0] t, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [31:0] imm, input logic last);
    set_fields(t, op, rd, rs1, rs2, f3, 7'd0, imm, last);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    set_fields(2'b00, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    check("rst_errs", 64'({err_range, err_full}), 64'd0);
    check("rst_addr_data", 64'({mem_addr, mem_wdata, err_addr}), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    reset = 1'b0;
    tick();

    // Two-word program: addi then sw with in_last
    do_start();
    check("start_busy_ready", 64'({busy, in_ready}), 64'h3);
    send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0);
    check("addi_we", 64'(mem_we), 64'd1);
    check("addi_addr", 64'(mem_addr), 64'd0);
    check("addi_data", 64'(mem_wdata), 64'h0050_0093);
    check("addi_wc", 64'(word_count), 64'd1);
    send(2'b01, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'hFFFF_FFFC, 1'b1);
    check("sw_we_addr", 64'({mem_we, mem_addr}), 64'h101);
    check("sw_data", 64'(mem_wdata), 64'hFE20_AE23);
    check("drain_ready_busy", 64'({in_ready, busy, done}), 64'b010);
    tick();
    check("done_state", 64'({mem_we, busy, done}), 64'b001);
    check("done_wc", 64'(word_count), 64'd2);
    check("done_noerr", 64'({err_range, err_full}), 64'd0);

    // Branch encodings: valid beq, then misaligned offset
    do_start();
    check("restart_wc", 64'(word_count), 64'd0);
    send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8, 1'b0);
    check("beq_data", 64'(mem_wdata), 64'hFE20_8CE3);
    check("beq_noerr", 64'(err_range), 64'd0);
    send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 1'b1);
    check("bodd_nop", 64'(mem_wdata), 64'(NOP));
    check("bodd_err", 64'({err_range, err_addr}), 64'h101);
    tick();
    check("bodd_done", 64'(done), 64'd1);

    // I-type immediate boundaries and first-error capture
    do_start();
    check("restart_err_clr", 64'({err_range, err_addr}), 64'd0);
    send(2'b00, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2047, 1'b0);
    check("imm_2047", 64'(mem_wdata), 64'h7FF0_0013);
    send(2'b00, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_F800, 1'b0);
    check("imm_m2048", 64'(mem_wdata), 64'h8000_0013);
    for (int i = 2; i < 5; i++) send(2'b00, 7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 32'(i), 1'b0);
    check("imm_small_data", 64'(mem_wdata), 64'h0040_0213);
    check("imm_no_err_yet", 64'(err_range), 64'd0);
    send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b0);
    check("imm_2048_nop", 64'({mem_addr, mem_wdata}), {24'd0, 8'd5, NOP});
    check("imm_2048_err", 64'({err_range, err_addr}), 64'h105);
    send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4096, 1'b1);
    check("imm_4096_nop", 64'({mem_addr, mem_wdata}), {24'd0, 8'd6, NOP});
    check("imm_first_err_kept", 64'({err_range, err_addr}), 64'h105);
    tick();

    // Fill all 256 words with R-type sub, no in_last
    do_start();
    set_fields(2'b11, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      check("fill_we_addr", 64'({mem_we, mem_addr}), 64'h100 | 64'(i));
      if (i == 0) check("sub_data", 64'(mem_wdata), 64'h4020_81B3);
      if (i == 254) check("fill_ready_mid", 64'({in_ready, err_full}), 64'b10);
    end
    check("full_drain", 64'({in_ready, busy, err_full}), 64'b011);
    tick();
    in_valid = 1'b0;
    check("full_done", 64'({mem_we, in_ready, done}), 64'b001);
    check("full_wc", 64'(word_count), 64'd256);

    // Alternating valid with a start pulse in LOAD that must be ignored
    do_start();
    for (int k = 0; k < 4; k++) begin
      set_fields(2'b00, 7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), k == 3);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("tog_we_addr", 64'({mem_we, mem_addr}), 64'h100 | 64'(k));
      start = (k == 1);
      tick();
      start = 1'b0;
      check("tog_gap_we", 64'(mem_we), 64'd0);
      if (k < 3) check("tog_ready", 64'(in_ready), 64'd1);
    end
    check("tog_done_wc", 64'({done, word_count}), 64'h204);

    // Reset right after an accept drops state and outputs
    do_start();
    send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0);
    check("pre_rst_we", 64'(mem_we), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_we", 64'(mem_we), 64'd0);
    check("midrst_flags", 64'({in_ready, busy, done, err_range, err_full}), 64'd0);
    check("midrst_vals", 64'({mem_addr, mem_wdata, word_count}), 64'd0);
    do_start();
    send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1);
    check("reload_addr0", 64'({mem_we, mem_addr, mem_wdata}), {23'd0, 1'b1, 8'd0, 32'h0050_0093});
    tick();
    check("reload_done", 64'({done, word_count}), 64'h201);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
